// File: rtl/fx2lp_stream_writer_pkg.sv
// Shared constants for the FX2LP slave-FIFO stream writer: endpoint
// addresses, flag bit positions, bus geometry and the writer FSM encoding.
package fx2lp_stream_writer_pkg;

  // FIFOADR codes selecting the FX2LP endpoint FIFOs.
  typedef enum logic [1:0] {
    EP2_ADDR = 2'b00,
    EP4_ADDR = 2'b01,
    EP6_ADDR = 2'b10,
    EP8_ADDR = 2'b11
  } ep_addr_e;

  // Positions of the FX2LP FLAGA/B/C pins within flag_n.
  typedef enum int {
    FLAG_A_IDX = 0,
    FLAG_B_IDX = 1,
    FLAG_C_IDX = 2
  } flag_idx_e;

  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;
  localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

  // Writer FSM encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Byte idx of a sample word; idx 0 is i[7:0], idx 3 is q[15:8].
  function automatic logic [BYTE_W-1:0] word_byte(
    input logic [BYTE_W*WORD_BYTES-1:0] word,
    input logic [1:0]                   idx
  );
    return word[BYTE_W*idx +: BYTE_W];
  endfunction

endpackage

// File: rtl/fx2lp_idle_timer.sv
// Idle timer for the stream writer: counts idle cycles while a partial
// packet is pending, saturates at IDLE_TIMEOUT and flags expiry.
// IDLE_TIMEOUT = 0 disables expiry altogether.
module fx2lp_idle_timer #(
  parameter int IDLE_TIMEOUT = 4096
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int CNT_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(IDLE_TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and hold at the limit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the reset branch is in the sensitivity list, so it acts immediately, without a clock.
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (IDLE_TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/fx2lp_stream_writer.sv
// Streams 32-bit {Q,I} sample words into the FX2LP slave FIFO as four bytes
// (i[7:0], i[15:8], q[7:0], q[15:8]) and flushes short packets with PKTEND
// once the stream has been idle for IDLE_TIMEOUT cycles.
module fx2lp_stream_writer
  import fx2lp_stream_writer_pkg::*;
#(
  parameter logic [1:0] FIFO_ADDR    = EP6_ADDR,
  parameter int         FULL_IDX     = FLAG_B_IDX,
  parameter int         PKT_BYTES    = 512,
  parameter int         IDLE_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  fd,
  output logic        slwr_n,
  output logic        slrd_n,
  output logic        sloe_n,
  output logic [1:0]  fifoadr,
  output logic        pktend_n,
  input  logic [2:0]  flag_n
);

  localparam int PKT_W = $clog2(PKT_BYTES);
  localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(PKT_BYTES - 1);

  logic [2:0]       flag_q;
  logic [1:0]       state_q, state_d;
  logic [31:0]      hold_q, hold_d;
  logic             hold_v_q, hold_v_d;
  logic             in_ready_q;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [PKT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [7:0]       fd_q, fd_d;
  logic             slwr_n_q, slwr_n_d;
  logic             pktend_n_q, pktend_n_d;

  logic ok, accept, byte_wr, timer_inc, timer_clear, timer_expired, flush_go;
  logic unused_flag_bits;

  // The almost-full flag leaves room for the flag register plus output register latency.
  assign ok               = flag_q[FULL_IDX];
  assign unused_flag_bits = ^flag_q;

  assign accept   = in_valid & in_ready_q;
  assign byte_wr  = (state_q == ST_SEND) & ok;
  assign flush_go = timer_expired & ok & ~hold_v_q & (pkt_cnt_q != '0);

  assign timer_inc   = (state_q == ST_IDLE) & ~hold_v_q & (pkt_cnt_q != '0);
  assign timer_clear = accept | byte_wr | (state_q == ST_FLUSH);

  fx2lp_idle_timer #(
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) u_idle_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (timer_clear),
    .inc_i    (timer_inc),
    .expired_o(timer_expired)
  );

  // Next-state logic for the FSM, holding register and registered bus outputs.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_v_d   = hold_v_q;
    byte_idx_d = byte_idx_q;
    pkt_cnt_d  = pkt_cnt_q;
    fd_d       = fd_q;
    slwr_n_d   = 1'b1;
    pktend_n_d = 1'b1;

    if (accept) begin
      hold_d   = in_data;
      hold_v_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // A pending flush beats a word arriving this cycle; the word waits in hold.
        if (hold_v_q && ok) begin
          state_d    = ST_SEND;
          byte_idx_d = '0;
        end else if (flush_go) begin
          state_d = ST_FLUSH;
        end else if (accept && ok) begin
          state_d    = ST_SEND;
          byte_idx_d = '0;
        end
      end
      ST_SEND: begin
        // Without room the byte index is held, so the stalled byte is neither lost nor repeated.
        if (ok) begin
          fd_d       = word_byte(hold_q, byte_idx_q);
          slwr_n_d   = 1'b0;
          byte_idx_d = byte_idx_q + 2'd1;
          pkt_cnt_d  = (pkt_cnt_q == PKT_LAST) ? '0 : pkt_cnt_q + 1'b1;
          if (byte_idx_q == LAST_BYTE) begin
            hold_v_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_FLUSH: begin
        pktend_n_d = 1'b0;
        pkt_cnt_d  = '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset discards any partially written word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_q     <= 3'b111;
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      hold_v_q   <= 1'b0;
      in_ready_q <= 1'b0;
      byte_idx_q <= '0;
      pkt_cnt_q  <= '0;
      fd_q       <= '0;
      slwr_n_q   <= 1'b1;
      pktend_n_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      flag_q     <= flag_n;
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_v_q   <= hold_v_d;
      in_ready_q <= ~hold_v_d;
      byte_idx_q <= byte_idx_d;
      pkt_cnt_q  <= pkt_cnt_d;
      fd_q       <= fd_d;
      slwr_n_q   <= slwr_n_d;
      pktend_n_q <= pktend_n_d;
    end
  end

  assign in_ready = in_ready_q;
  assign fd       = fd_q;
  assign slwr_n   = slwr_n_q;
  assign pktend_n = pktend_n_q;
  assign slrd_n   = 1'b1;
  assign sloe_n   = 1'b1;
  assign fifoadr  = FIFO_ADDR;

endmodule

// File: tb/tb_fx2lp_stream_writer.sv
// Directed bench for fx2lp_stream_writer: byte order, flag stalls, packet
// wrap, idle flush timing, disabled flush and asynchronous mid-word reset.
module tb_fx2lp_stream_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic [2:0]  flag_n;

  logic        in_ready, slwr_n, slrd_n, sloe_n, pktend_n;
  logic [7:0]  fd;
  logic [1:0]  fifoadr;

  logic        unused_ready_z, unused_slwr_z, unused_slrd_z, unused_sloe_z, pktend_n_z;
  logic [7:0]  unused_fd_z;
  logic [1:0]  unused_fifoadr_z;

  always #5 clk = ~clk;

  fx2lp_stream_writer #(.IDLE_TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .fd(fd), .slwr_n(slwr_n), .slrd_n(slrd_n),
    .sloe_n(sloe_n), .fifoadr(fifoadr), .pktend_n(pktend_n), .flag_n(flag_n)
  );

  fx2lp_stream_writer #(.IDLE_TIMEOUT(0)) dut_z (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(unused_ready_z), .fd(unused_fd_z), .slwr_n(unused_slwr_z),
    .slrd_n(unused_slrd_z), .sloe_n(unused_sloe_z), .fifoadr(unused_fifoadr_z),
    .pktend_n(pktend_n_z), .flag_n(flag_n)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Bus monitor state, sampled on the falling edge.
  int         cyc = 0;
  logic [7:0] byte_q[$];
  int         wr_cyc_q[$];
  int         pkt_pulses = 0, pkt_run = 0, pkt_long = 0, last_pkt_cyc = 0;
  int         pkt_low_z = 0, both_low = 0;

  always @(negedge clk) begin
    cyc++;
    if (reset_n) begin
      if (!slwr_n) begin
        byte_q.push_back(fd);
        wr_cyc_q.push_back(cyc);
      end
      if (!pktend_n) begin
        if (pkt_run == 0) pkt_pulses++;
        pkt_run++;
        if (pkt_run > 1) pkt_long++;
        last_pkt_cyc = cyc;
      end else begin
        pkt_run = 0;
      end
      if (!pktend_n_z) pkt_low_z++;
      if (!slwr_n && !pktend_n) both_low++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Advance to just after the next falling edge (monitor already updated).
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      tick(1);
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int target, input int budget);
    int n = 0;
    while (byte_q.size() < target && n < budget) begin
      tick(1);
      n++;
    end
    if (byte_q.size() < target) check("byte_wait_timeout", byte_q.size(), target);
  endtask

  function automatic logic [7:0] got_byte(input int k);
    return (k < byte_q.size()) ? byte_q[k] : 8'hxx;
  endfunction

  function automatic int got_cyc(input int k);
    return (k < wr_cyc_q.size()) ? wr_cyc_q[k] : -1000;
  endfunction

  function automatic logic [31:0] stream_word(input int i);
    logic [7:0] b = 8'(i);
    return {b, ~b, b + 8'h40, b ^ 8'h5A};
  endfunction

  typedef struct {
    logic [31:0] word;
    logic [31:0] exp_seq;  // expected fd bytes in write order, first byte in [31:24]
  } vec_t;

  initial begin
    vec_t        vecs[3];
    logic [31:0] seq;
    int          last_wr;
    int          mism;
    logic [31:0] w;

    vecs[0] = '{32'hA1B2C3D4, 32'hD4C3B2A1};
    vecs[1] = '{32'h00FF1234, 32'h3412FF00};
    vecs[2] = '{32'hDEADBEEF, 32'hEFBEADDE};

    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    flag_n   = 3'b111;

    // Reset state and constant outputs.
    tick(3);
    check("rst_fd", fd, 8'h00);
    check("rst_slwr_n", slwr_n, 1'b1);
    check("rst_pktend_n", pktend_n, 1'b1);
    check("rst_in_ready", in_ready, 1'b0);
    check("slrd_n", slrd_n, 1'b1);
    check("sloe_n", sloe_n, 1'b1);
    check("fifoadr", fifoadr, 2'b10);
    reset_n = 1'b1;
    tick(2);
    check("ready_after_reset", in_ready, 1'b1);

    // Single words: byte order and four consecutive strobes.
    for (int i = 0; i < 3; i++) begin
      byte_q.delete();
      wr_cyc_q.delete();
      send_word(vecs[i].word);
      wait_bytes(4, 40);
      tick(2);
      seq = vecs[i].exp_seq;
      for (int j = 0; j < 4; j++) begin
        check($sformatf("vec%0d_byte%0d", i, j), got_byte(j), seq[31-8*j -: 8]);
      end
      check($sformatf("vec%0d_count", i), byte_q.size(), 4);
      check($sformatf("vec%0d_span", i), got_cyc(3) - got_cyc(0), 3);
    end
    check("no_pktend_while_streaming", pkt_pulses, 0);

    // 12 bytes pending, then idle: one PKTEND pulse after the timeout, then silence.
    last_wr = got_cyc(3);
    tick(40);
    check("flush_count", pkt_pulses, 1);
    check_range("flush_delay", last_pkt_cyc - last_wr, 17, 18);
    tick(100);
    check("flush_once_only", pkt_pulses, 1);

    // Almost-full held for 3 registered cycles after byte 1.
    byte_q.delete();
    wr_cyc_q.delete();
    send_word(32'hA1B2C3D4);
    wait_bytes(2, 40);
    flag_n[1] = 1'b0;
    tick(3);
    flag_n[1] = 1'b1;
    wait_bytes(4, 40);
    tick(3);
    check("stall_byte0", got_byte(0), 8'hD4);
    check("stall_byte1", got_byte(1), 8'hC3);
    check("stall_byte2", got_byte(2), 8'hB2);
    check("stall_byte3", got_byte(3), 8'hA1);
    check("stall_count", byte_q.size(), 4);
    check("stall_gap", got_cyc(3) - got_cyc(2), 4);
    tick(40);
    check("stall_flush_count", pkt_pulses, 2);

    // Full packet: 128 words -> 512 bytes, counter wraps, no flush afterwards.
    byte_q.delete();
    wr_cyc_q.delete();
    for (int i = 0; i < 128; i++) send_word(stream_word(i));
    wait_bytes(512, 2000);
    mism = 0;
    for (int k = 0; k < 512; k++) begin
      w = stream_word(k / 4);
      if (got_byte(k) !== w[8*(k%4) +: 8]) mism++;
    end
    check("stream_bytes", byte_q.size(), 512);
    check("stream_data_errors", mism, 0);
    tick(200);
    check("stream_no_pktend", pkt_pulses, 2);

    // Reset while byte 2 is on the bus: outputs drop without a clock edge.
    byte_q.delete();
    wr_cyc_q.delete();
    send_word(32'h11223344);
    wait_bytes(2, 40);
    tick(1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_slwr_n", slwr_n, 1'b1);
    check("async_rst_fd", fd, 8'h00);
    check("async_rst_in_ready", in_ready, 1'b0);
    check("async_rst_pktend_n", pktend_n, 1'b1);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    byte_q.delete();
    wr_cyc_q.delete();
    send_word(32'h55667788);
    wait_bytes(4, 40);
    check("post_rst_byte0", got_byte(0), 8'h88);
    check("post_rst_byte1", got_byte(1), 8'h77);
    check("post_rst_byte2", got_byte(2), 8'h66);
    check("post_rst_byte3", got_byte(3), 8'h55);

    // Long idle: the timeout-16 writer flushes once, the disabled one never does.
    tick(10000);
    check("final_flush_count", pkt_pulses, 3);
    check("disabled_flush_low_cycles", pkt_low_z, 0);
    check("pktend_width", pkt_long, 0);
    check("slwr_pktend_overlap", both_low, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
